// File: rtl/boundary_scan_chain.sv
// boundary_scan_chain: JTAG boundary-scan data register wrapped around an N-bit adder.
// Optional macro BSC_TDO_NEGEDGE_EN retimes TDO through a falling-edge flop.
module boundary_scan_chain #(
    parameter int N = 16
) (
    input  logic         ClockDR,
    input  logic         Reset,
    input  logic         TDI,
    input  logic         ShiftDR,
    input  logic         UpdateDR,
    input  logic         Mode,
    input  logic [N-1:0] sys_pin_a,
    input  logic [N-1:0] sys_pin_b,
    input  logic         sys_pin_cin,
    input  logic         sys_pin_sel,
    input  logic [N-1:0] module_pin_sum,
    input  logic         module_pin_co,
    output logic [N-1:0] module_pin_a,
    output logic [N-1:0] module_pin_b,
    output logic         module_pin_cin,
    output logic         module_pin_sel,
    output logic [N-1:0] sys_pin_sum,
    output logic         sys_pin_co,
    output logic         TDO
);

    localparam int L = 3 * N + 3;

    logic [L-1:0] pi;
    logic [L-1:0] cap;
    logic [L-1:0] upd;
    logic [L-1:0] po;

    // Bit 0 is the cell nearest TDI, bit L-1 (co) is the cell nearest TDO.
    assign pi = {module_pin_co, module_pin_sum,
                 sys_pin_sel, sys_pin_cin,
                 sys_pin_b, sys_pin_a};

    // Capture stage: shift toward TDO or sample the parallel inputs.
    always_ff @(posedge ClockDR or posedge Reset) begin
        if (Reset) begin
            cap <= '0;
        end else if (ShiftDR) begin
            cap <= {cap[L-2:0], TDI};
        end else begin
            cap <= pi;
        end
    end

    // Update stage: takes the capture contents as they were before the edge.
    always_ff @(posedge ClockDR or posedge Reset) begin
        if (Reset) begin
            upd <= '0;
        end else if (UpdateDR) begin
            upd <= cap;
        end
    end

    assign po = Mode ? upd : pi;

    assign module_pin_a   = po[N-1:0];
    assign module_pin_b   = po[2*N-1:N];
    assign module_pin_cin = po[2*N];
    assign module_pin_sel = po[2*N+1];
    assign sys_pin_sum    = po[3*N+1:2*N+2];
    assign sys_pin_co     = po[3*N+2];

`ifdef BSC_TDO_NEGEDGE_EN
    logic tdo_q;

    // Half-cycle retiming so TDO changes on the falling edge of ClockDR.
    always_ff @(negedge ClockDR or posedge Reset) begin
        if (Reset) begin
            tdo_q <= 1'b0;
        end else begin
            tdo_q <= cap[L-1];
        end
    end

    assign TDO = tdo_q;
`else
    assign TDO = cap[L-1];
`endif

endmodule

// File: tb/tb_boundary_scan_chain.sv
// tb_boundary_scan_chain: vector table plus TDO scoreboard for boundary_scan_chain.
// Samples outputs 7 time units after each rising edge, after the falling edge.
module tb_boundary_scan_chain;

    localparam int N = 16;
    localparam int L = 3 * N + 3;

    logic         ClockDR = 1'b0;
    logic         Reset;
    logic         TDI;
    logic         ShiftDR;
    logic         UpdateDR;
    logic         Mode;
    logic [N-1:0] sys_pin_a;
    logic [N-1:0] sys_pin_b;
    logic         sys_pin_cin;
    logic         sys_pin_sel;
    logic [N-1:0] module_pin_sum;
    logic         module_pin_co;
    logic [N-1:0] module_pin_a;
    logic [N-1:0] module_pin_b;
    logic         module_pin_cin;
    logic         module_pin_sel;
    logic [N-1:0] sys_pin_sum;
    logic         sys_pin_co;
    logic         TDO;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];
    logic [L-1:0] mdl;
    logic [L-1:0] pre;

    typedef struct {
        logic         mode;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sel;
        logic [N-1:0] sum;
        logic         co;
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic         ecin;
        logic         esel;
        logic [N-1:0] esum;
        logic         eco;
    } vec_t;

    vec_t tbl[5];

    boundary_scan_chain #(.N(N)) dut (
        .ClockDR        (ClockDR),
        .Reset          (Reset),
        .TDI            (TDI),
        .ShiftDR        (ShiftDR),
        .UpdateDR       (UpdateDR),
        .Mode           (Mode),
        .sys_pin_a      (sys_pin_a),
        .sys_pin_b      (sys_pin_b),
        .sys_pin_cin    (sys_pin_cin),
        .sys_pin_sel    (sys_pin_sel),
        .module_pin_sum (module_pin_sum),
        .module_pin_co  (module_pin_co),
        .module_pin_a   (module_pin_a),
        .module_pin_b   (module_pin_b),
        .module_pin_cin (module_pin_cin),
        .module_pin_sel (module_pin_sel),
        .sys_pin_sum    (sys_pin_sum),
        .sys_pin_co     (sys_pin_co),
        .TDO            (TDO)
    );

    always #5 ClockDR = ~ClockDR;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ClockDR);
        #7;
    endtask

    task automatic tick_pop(input string nm);
        tick();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, TDO=%0b", nm, TDO);
        end else begin
            chk(nm, 64'(TDO), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic chk_po(input string nm, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic cin,
                          input logic sel, input logic [N-1:0] sum,
                          input logic co);
        chk({nm, "_a"}, 64'(module_pin_a), 64'(a));
        chk({nm, "_b"}, 64'(module_pin_b), 64'(b));
        chk({nm, "_cin"}, 64'(module_pin_cin), 64'(cin));
        chk({nm, "_sel"}, 64'(module_pin_sel), 64'(sel));
        chk({nm, "_sum"}, 64'(sys_pin_sum), 64'(sum));
        chk({nm, "_co"}, 64'(sys_pin_co), 64'(co));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'hFF00, 1'b1,
                   16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'hFF00, 1'b1};
        tbl[1] = '{1'b0, 16'h1234, 16'hABCD, 1'b0, 1'b1, 16'h0F0F, 1'b0,
                   16'h1234, 16'hABCD, 1'b0, 1'b1, 16'h0F0F, 1'b0};
        tbl[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1,
                   16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[3] = '{1'b1, 16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 16'h1111, 1'b1,
                   16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h00FF, 1'b0,
                   16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h00FF, 1'b0};

        Reset = 1'b1;
        TDI = 1'b0;
        ShiftDR = 1'b0;
        UpdateDR = 1'b0;
        Mode = 1'b0;
        sys_pin_a = '0;
        sys_pin_b = '0;
        sys_pin_cin = 1'b0;
        sys_pin_sel = 1'b0;
        module_pin_sum = '0;
        module_pin_co = 1'b0;

        // Pass-through and Mode=1 under reset
        for (int i = 0; i < 5; i++) begin
            Mode = tbl[i].mode;
            sys_pin_a = tbl[i].a;
            sys_pin_b = tbl[i].b;
            sys_pin_cin = tbl[i].cin;
            sys_pin_sel = tbl[i].sel;
            module_pin_sum = tbl[i].sum;
            module_pin_co = tbl[i].co;
            #3;
            chk_po($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb,
                   tbl[i].ecin, tbl[i].esel, tbl[i].esum, tbl[i].eco);
            chk($sformatf("vec%0d_tdo", i), 64'(TDO), 64'd0);
        end

        // Capture then shift out with TDI=0
        Mode = 1'b0;
        sys_pin_a = 16'hFFFF;
        sys_pin_b = 16'h0000;
        sys_pin_cin = 1'b1;
        sys_pin_sel = 1'b1;
        module_pin_sum = 16'hFF00;
        module_pin_co = 1'b1;
        tick();
        Reset = 1'b0;
        chk_po("pass", 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'hFF00, 1'b1);
        ShiftDR = 1'b0;
        exp_q.push_back(1'b1);
        tick_pop("capture_co");
        ShiftDR = 1'b1;
        TDI = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = 0; i < L; i++) tick_pop($sformatf("shout_%0d", i));

        // Latency: a single 1 reaches TDO after exactly L edges
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        ShiftDR = 1'b1;
        TDI = 1'b1;
        for (int i = 1; i <= L + 1; i++) begin
            exp_q.push_back(i == L);
            tick_pop($sformatf("lat_%0d", i));
            TDI = 1'b0;
        end

        // Shift in ones, update, then drive outputs from U
        TDI = 1'b1;
        for (int i = 0; i < L; i++) tick();
        UpdateDR = 1'b1;
        tick();
        UpdateDR = 1'b0;
        sys_pin_a = 16'h0000;
        module_pin_sum = 16'h0000;
        Mode = 1'b1;
        #1;
        chk_po("upd", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        chk("upd_tdo", 64'(TDO), 64'd1);

        // Reset in the middle of a shift clears TDO and PO at once
        Reset = 1'b1;
        #1;
        chk("rst_tdo", 64'(TDO), 64'd0);
        chk_po("rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        Reset = 1'b0;

        // Simultaneous shift and update
        Mode = 1'b0;
        mdl = '0;
        for (int k = 0; k < L; k++) begin
            TDI = (k % 2 == 0);
            tick();
            mdl = {mdl[L-2:0], TDI};
        end
        pre = mdl;
        TDI = 1'b0;
        UpdateDR = 1'b1;
        Mode = 1'b1;
        exp_q.push_back(pre[L-2]);
        tick_pop("sim_tdo0");
        UpdateDR = 1'b0;
        chk("sim_pattern_a", 64'(module_pin_a), 64'h5555);
        chk_po("sim", pre[N-1:0], pre[2*N-1:N], pre[2*N], pre[2*N+1],
               pre[3*N+1:2*N+2], pre[3*N+2]);
        for (int i = 3; i <= 5; i++) begin
            exp_q.push_back(pre[L-i]);
            tick_pop($sformatf("sim_tdo%0d", i - 2));
        end
        chk("sim_hold_a", 64'(module_pin_a), 64'(pre[N-1:0]));
        chk("sim_hold_co", 64'(sys_pin_co), 64'(pre[3*N+2]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boundary_scan_chain.md
# boundary_scan_chain

Boundary-scan data register for the JTAG wrapper around the N-bit ripple-carry adder. It sits between the system pins and the adder core. Every adder input and output pin gets one boundary-scan cell (BSC). The cells are chained serially from TDI to TDO and driven by the TAP controller's ShiftDR, ClockDR, UpdateDR and Mode controls.

## Interface
Parameters:
- N, 16, adder operand width; chain length L = 3N+3 (51 at default).

Ports:
- ClockDR  in  1  scan clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all capture/update flops.
- TDI  in  1  serial scan input.
- ShiftDR  in  1  1 = shift the chain, 0 = capture parallel inputs.
- UpdateDR  in  1  1 = load the update stage from the capture stage.
- Mode  in  1  0 = functional pass-through, 1 = drive outputs from the update stage.
- sys_pin_a, sys_pin_b  in  N  operand inputs from the system pins.
- sys_pin_cin, sys_pin_sel  in  1  carry-in and select inputs from the system pins.
- module_pin_sum  in  N  sum from the adder core.
- module_pin_co  in  1  carry-out from the adder core.
- module_pin_a, module_pin_b  out  N  operands to the core.
- module_pin_cin, module_pin_sel  out  1  carry-in and select to the core.
- sys_pin_sum  out  N  sum to the system pins.
- sys_pin_co  out  1  carry-out to the system pins.
- TDO  out  1  serial scan output.

## Operation
- Each cell holds a capture flop (C), an update flop (U), a parallel input PI and a parallel output PO.
- Chain order, TDI to TDO: a[0]..a[N-1], b[0]..b[N-1], cin, sel, sum[0]..sum[N-1], co.
- TDO is the C flop of the co cell.
- On each ClockDR rising edge:
  - ShiftDR=1: C of each cell loads the previous cell's C (the first cell loads TDI).
  - ShiftDR=0: C loads PI.
- On the same edge, if UpdateDR=1, U loads C. U takes the pre-edge C value.
- With ShiftDR=1 and UpdateDR=1 on the same edge, the update stage receives the pre-shift contents while the chain also shifts.
- PO = Mode ? U : PI, combinational, for every cell:
  - input cells drive module_pin_*;
  - output cells drive sys_pin_sum and sys_pin_co.
- Reset: all C and U flops go to 0 and TDO = 0.
- Mode=0 under reset still passes PI straight to PO.
- Mode=1 under reset drives all PO to 0.

## Timing
- Capture: parallel values appear in C one ClockDR edge after ShiftDR=0. The co value is on TDO immediately after that edge.
- Shift: a bit presented on TDI appears on TDO after exactly L rising edges.
- Update: PO reflects the new U value right after the edge on which UpdateDR=1, provided Mode=1.
- Mode changes take effect combinationally, with zero cycles of latency.
- Reset is asynchronous on assertion. Release is synchronous-safe: the first edge after deassertion operates normally.

## Configuration
- BSC_TDO_NEGEDGE_EN:
  - Defined: TDO is retimed through an extra flop clocked on the falling edge of ClockDR. The flop is reset to 0. This gives JTAG-compliant half-cycle output timing.
  - Undefined: TDO is wired directly to the last C flop.
  - Shift length in rising edges is unchanged.

## Test plan
- Pass-through: Reset=1 then 0, Mode=0, sys_pin_a=16'hFFFF, b=0, cin=1, sel=1, module_pin_sum=16'hFF00, co=1. Required: module_pin_a=FFFF, module_pin_b=0, module_pin_cin=1, module_pin_sel=1, sys_pin_sum=FF00, sys_pin_co=1, TDO=0.
- Capture and shift-out: apply the inputs above, give one edge with ShiftDR=0, then shift with TDI=0. Required TDO sequence after the capture edge:
  - 1 (co);
  - then 1×8 (sum[15:8]) and 0×8 (sum[7:0]);
  - then 1 (sel) and 1 (cin);
  - then 0×16 (b) and 1×16 (a);
  - then 0.
- Shift and update: shift 51 ones, then one edge with UpdateDR=1, then Mode=1, while sys_pin_a=0 and module_pin_sum=0. Required: module_pin_a=module_pin_b=FFFF, cin=sel=1, sys_pin_sum=FFFF, sys_pin_co=1.
- Latency: after reset, set TDI=1 for one edge and 0 thereafter. Required: TDO first reads 1 after the 51st rising edge.
- Simultaneous shift and update: chain loaded with alternating 1010…, then one edge with ShiftDR=1 and UpdateDR=1, Mode=1. Required: U holds the pre-shift pattern; TDO shows the shifted pattern.
- Reset mid-operation: assert Reset during a shift with Mode=1. Required: TDO=0 and all PO=0 immediately, without waiting for a clock edge.
